// File: rtl/carpark_occupancy.sv
// Car park occupancy tracker: per-lane two-beam direction FSMs feeding a saturating occupancy counter.
// Optional macro CARPARK_SYNC_EN inserts a two-flop synchroniser on every a/b sensor bit.
module carpark_occupancy #(
   parameter int LANES    = 2,
   parameter int CAPACITY = 100,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [LANES-1:0] a_i,
   input  logic [LANES-1:0] b_i,
   input  logic             clr_err_i,
   output logic [LANES-1:0] enter_o,
   output logic [LANES-1:0] exit_o,
   output logic [CNT_W-1:0] count_o,
   output logic             full_o,
   output logic             empty_o,
   output logic             err_ovf_o,
   output logic             err_unf_o
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_ENT_A  = 3'd1;
   localparam logic [2:0] ST_ENT_AB = 3'd2;
   localparam logic [2:0] ST_ENT_B  = 3'd3;
   localparam logic [2:0] ST_LV_B   = 3'd4;
   localparam logic [2:0] ST_LV_AB  = 3'd5;
   localparam logic [2:0] ST_LV_A   = 3'd6;

   localparam int SUM_W = CNT_W + 4;
   localparam logic signed [SUM_W-1:0] CAP_S  = SUM_W'(CAPACITY);
   localparam logic signed [SUM_W-1:0] ZERO_S = {SUM_W{1'b0}};
   localparam logic [CNT_W-1:0]        CAP_C  = CNT_W'(CAPACITY);

   logic [LANES-1:0] a_s;
   logic [LANES-1:0] b_s;

`ifdef CARPARK_SYNC_EN
   logic [LANES-1:0] a_meta_q;
   logic [LANES-1:0] a_sync_q;
   logic [LANES-1:0] b_meta_q;
   logic [LANES-1:0] b_sync_q;

   // Two-flop synchroniser for the asynchronous beam sensors
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_meta_q <= {LANES{1'b0}};
         a_sync_q <= {LANES{1'b0}};
         b_meta_q <= {LANES{1'b0}};
         b_sync_q <= {LANES{1'b0}};
      end else begin
         a_meta_q <= a_i;
         a_sync_q <= a_meta_q;
         b_meta_q <= b_i;
         b_sync_q <= b_meta_q;
      end
   end

   assign a_s = a_sync_q;
   assign b_s = b_sync_q;
`else
   assign a_s = a_i;
   assign b_s = b_i;
`endif

   logic [2:0]       state_q [LANES];
   logic [2:0]       state_d [LANES];
   logic [LANES-1:0] ent_s;
   logic [LANES-1:0] ext_s;

   // Per-lane direction FSM; a completed sequence only counts when both beams clear
   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         state_d[i] = ST_IDLE;
         ent_s[i]   = 1'b0;
         ext_s[i]   = 1'b0;
         case (state_q[i])
            ST_IDLE: begin
               case ({a_s[i], b_s[i]})
                  2'b10:   state_d[i] = ST_ENT_A;
                  2'b01:   state_d[i] = ST_LV_B;
                  default: state_d[i] = ST_IDLE;
               endcase
            end
            ST_ENT_A: begin
               case ({a_s[i], b_s[i]})
                  2'b10:   state_d[i] = ST_ENT_A;
                  2'b11:   state_d[i] = ST_ENT_AB;
                  default: state_d[i] = ST_IDLE;
               endcase
            end
            ST_ENT_AB: begin
               case ({a_s[i], b_s[i]})
                  2'b11:   state_d[i] = ST_ENT_AB;
                  2'b01:   state_d[i] = ST_ENT_B;
                  default: state_d[i] = ST_IDLE;
               endcase
            end
            ST_ENT_B: begin
               case ({a_s[i], b_s[i]})
                  2'b01:   state_d[i] = ST_ENT_B;
                  2'b00:   begin
                     state_d[i] = ST_IDLE;
                     ent_s[i]   = 1'b1;
                  end
                  default: state_d[i] = ST_IDLE;
               endcase
            end
            ST_LV_B: begin
               case ({a_s[i], b_s[i]})
                  2'b01:   state_d[i] = ST_LV_B;
                  2'b11:   state_d[i] = ST_LV_AB;
                  default: state_d[i] = ST_IDLE;
               endcase
            end
            ST_LV_AB: begin
               case ({a_s[i], b_s[i]})
                  2'b11:   state_d[i] = ST_LV_AB;
                  2'b10:   state_d[i] = ST_LV_A;
                  default: state_d[i] = ST_IDLE;
               endcase
            end
            ST_LV_A: begin
               case ({a_s[i], b_s[i]})
                  2'b10:   state_d[i] = ST_LV_A;
                  2'b00:   begin
                     state_d[i] = ST_IDLE;
                     ext_s[i]   = 1'b1;
                  end
                  default: state_d[i] = ST_IDLE;
               endcase
            end
            default: state_d[i] = ST_IDLE;
         endcase
      end
   end

   logic [CNT_W-1:0]        count_q;
   logic [CNT_W-1:0]        count_d;
   logic                    full_q;
   logic                    full_d;
   logic                    empty_q;
   logic                    empty_d;
   logic                    err_ovf_q;
   logic                    err_ovf_d;
   logic                    err_unf_q;
   logic                    err_unf_d;
   logic [LANES-1:0]        enter_q;
   logic [LANES-1:0]        exit_q;
   logic signed [SUM_W-1:0] n_ent_s;
   logic signed [SUM_W-1:0] n_ext_s;
   logic signed [SUM_W-1:0] sum_s;
   logic                    ovf_s;
   logic                    unf_s;

   // Net all lanes first, then saturate, so balanced traffic never flags an error
   always_comb begin
      n_ent_s = ZERO_S;
      n_ext_s = ZERO_S;
      for (int i = 0; i < LANES; i++) begin
         n_ent_s = n_ent_s + $signed({{(SUM_W-1){1'b0}}, ent_s[i]});
         n_ext_s = n_ext_s + $signed({{(SUM_W-1){1'b0}}, ext_s[i]});
      end
      sum_s = $signed({4'b0000, count_q}) + n_ent_s - n_ext_s;
      ovf_s = 1'b0;
      unf_s = 1'b0;
      if (sum_s > CAP_S) begin
         count_d = CAP_C;
         ovf_s   = 1'b1;
      end else if (sum_s < ZERO_S) begin
         count_d = {CNT_W{1'b0}};
         unf_s   = 1'b1;
      end else begin
         count_d = sum_s[CNT_W-1:0];
      end
      full_d    = (count_d == CAP_C);
      empty_d   = (count_d == {CNT_W{1'b0}});
      err_ovf_d = ovf_s | (err_ovf_q & ~clr_err_i);
      err_unf_d = unf_s | (err_unf_q & ~clr_err_i);
   end

   // State, pulse and counter registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < LANES; i++) begin
            state_q[i] <= ST_IDLE;
         end
         enter_q   <= {LANES{1'b0}};
         exit_q    <= {LANES{1'b0}};
         count_q   <= {CNT_W{1'b0}};
         full_q    <= 1'b0;
         empty_q   <= 1'b1;
         err_ovf_q <= 1'b0;
         err_unf_q <= 1'b0;
      end else begin
         for (int i = 0; i < LANES; i++) begin
            state_q[i] <= state_d[i];
         end
         enter_q   <= ent_s;
         exit_q    <= ext_s;
         count_q   <= count_d;
         full_q    <= full_d;
         empty_q   <= empty_d;
         err_ovf_q <= err_ovf_d;
         err_unf_q <= err_unf_d;
      end
   end

   assign enter_o   = enter_q;
   assign exit_o    = exit_q;
   assign count_o   = count_q;
   assign full_o    = full_q;
   assign empty_o   = empty_q;
   assign err_ovf_o = err_ovf_q;
   assign err_unf_o = err_unf_q;

endmodule

// File: tb/tb_carpark_occupancy.sv
// Directed, table-driven bench for carpark_occupancy (LANES=2, CAPACITY=3, CNT_W=8).
module tb_carpark_occupancy;

   logic       clk;
   logic       reset;
   logic [1:0] a_i;
   logic [1:0] b_i;
   logic       clr_err_i;
   logic [1:0] enter_o;
   logic [1:0] exit_o;
   logic [7:0] count_o;
   logic       full_o;
   logic       empty_o;
   logic       err_ovf_o;
   logic       err_unf_o;

   int n_vec;
   int n_bad;

   typedef struct packed {
      logic [1:0] a;
      logic [1:0] b;
      logic       clr;
      logic [1:0] en;
      logic [1:0] ex;
      logic [7:0] cnt;
      logic       full;
      logic       empty;
      logic       ovf;
      logic       unf;
   } vec_t;

   vec_t tbl[$];

   carpark_occupancy #(.LANES(2), .CAPACITY(3), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .a_i(a_i), .b_i(b_i), .clr_err_i(clr_err_i),
      .enter_o(enter_o), .exit_o(exit_o), .count_o(count_o), .full_o(full_o),
      .empty_o(empty_o), .err_ovf_o(err_ovf_o), .err_unf_o(err_unf_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic add(input logic [1:0] a, input logic [1:0] b, input logic clr,
                      input logic [1:0] en, input logic [1:0] ex, input logic [7:0] cnt,
                      input logic full, input logic empty, input logic ovf, input logic unf);
      vec_t v;
      v = '{a: a, b: b, clr: clr, en: en, ex: ex, cnt: cnt,
            full: full, empty: empty, ovf: ovf, unf: unf};
      tbl.push_back(v);
   endtask

   task automatic check(input string name, input logic [1:0] en, input logic [1:0] ex,
                        input logic [7:0] cnt, input logic full, input logic empty,
                        input logic ovf, input logic unf);
      n_vec++;
      if (enter_o !== en || exit_o !== ex || count_o !== cnt || full_o !== full ||
          empty_o !== empty || err_ovf_o !== ovf || err_unf_o !== unf) begin
         n_bad++;
         $display("FAIL %s: got en=%b ex=%b cnt=%0d full=%b empty=%b ovf=%b unf=%b, want en=%b ex=%b cnt=%0d full=%b empty=%b ovf=%b unf=%b",
                  name, enter_o, exit_o, count_o, full_o, empty_o, err_ovf_o, err_unf_o,
                  en, ex, cnt, full, empty, ovf, unf);
      end
   endtask

   task automatic step(input logic [1:0] a, input logic [1:0] b);
      a_i = a;
      b_i = b;
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_vec = 0;
      n_bad = 0;
      reset = 1'b1;
      a_i = 2'b00;
      b_i = 2'b00;
      clr_err_i = 1'b0;

      // Lane bit 0 = lane0, bit 1 = lane1; a and b given per lane.
      //   a      b      clr   en     ex     cnt    f     e     ovf   unf
      add(2'b01, 2'b00, 1'b0, 2'b00, 2'b00, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      add(2'b01, 2'b01, 1'b0, 2'b00, 2'b00, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      add(2'b00, 2'b01, 1'b0, 2'b00, 2'b00, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      add(2'b00, 2'b00, 1'b0, 2'b01, 2'b00, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      // aborted entry: 10,11,10,00
      add(2'b01, 2'b00, 1'b0, 2'b00, 2'b00, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      add(2'b01, 2'b01, 1'b0, 2'b00, 2'b00, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      add(2'b01, 2'b00, 1'b0, 2'b00, 2'b00, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      add(2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      // both lanes enter together -> 3, full
      add(2'b11, 2'b00, 1'b0, 2'b00, 2'b00, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      add(2'b11, 2'b11, 1'b0, 2'b00, 2'b00, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      add(2'b00, 2'b11, 1'b0, 2'b00, 2'b00, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      add(2'b00, 2'b00, 1'b0, 2'b11, 2'b00, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      // lane1 entry at capacity -> overflow
      add(2'b10, 2'b00, 1'b0, 2'b00, 2'b00, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      add(2'b10, 2'b10, 1'b0, 2'b00, 2'b00, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      add(2'b00, 2'b10, 1'b0, 2'b00, 2'b00, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      add(2'b00, 2'b00, 1'b0, 2'b10, 2'b00, 8'd3, 1'b1, 1'b0, 1'b1, 1'b0);
      add(2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      // both lanes exit -> 1
      add(2'b00, 2'b11, 1'b0, 2'b00, 2'b00, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      add(2'b11, 2'b11, 1'b0, 2'b00, 2'b00, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      add(2'b11, 2'b00, 1'b0, 2'b00, 2'b00, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      add(2'b00, 2'b00, 1'b0, 2'b00, 2'b11, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      // lane0 entry with lane1 exit on the same edge -> nets out
      add(2'b01, 2'b10, 1'b0, 2'b00, 2'b00, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      add(2'b11, 2'b11, 1'b0, 2'b00, 2'b00, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      add(2'b10, 2'b01, 1'b0, 2'b00, 2'b00, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      add(2'b00, 2'b00, 1'b0, 2'b01, 2'b10, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      // lane0 exit -> 0
      add(2'b00, 2'b01, 1'b0, 2'b00, 2'b00, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      add(2'b01, 2'b01, 1'b0, 2'b00, 2'b00, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      add(2'b01, 2'b00, 1'b0, 2'b00, 2'b00, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      add(2'b00, 2'b00, 1'b0, 2'b00, 2'b01, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      // lane1 exit at zero -> underflow
      add(2'b00, 2'b10, 1'b0, 2'b00, 2'b00, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      add(2'b10, 2'b10, 1'b0, 2'b00, 2'b00, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      add(2'b10, 2'b00, 1'b0, 2'b00, 2'b00, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      add(2'b00, 2'b00, 1'b0, 2'b00, 2'b10, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      // new underflow on the clearing edge keeps the flag
      add(2'b00, 2'b10, 1'b0, 2'b00, 2'b00, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      add(2'b10, 2'b10, 1'b0, 2'b00, 2'b00, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      add(2'b10, 2'b00, 1'b0, 2'b00, 2'b00, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      add(2'b00, 2'b00, 1'b1, 2'b00, 2'b10, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      add(2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      // 11 from IDLE stays IDLE; 01,00 is then an aborted exit
      add(2'b01, 2'b01, 1'b0, 2'b00, 2'b00, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      add(2'b00, 2'b01, 1'b0, 2'b00, 2'b00, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      add(2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      // held inputs keep state through a full entry
      add(2'b01, 2'b00, 1'b0, 2'b00, 2'b00, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      add(2'b01, 2'b00, 1'b0, 2'b00, 2'b00, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      add(2'b01, 2'b01, 1'b0, 2'b00, 2'b00, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      add(2'b01, 2'b01, 1'b0, 2'b00, 2'b00, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      add(2'b00, 2'b01, 1'b0, 2'b00, 2'b00, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      add(2'b00, 2'b01, 1'b0, 2'b00, 2'b00, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      add(2'b00, 2'b00, 1'b0, 2'b01, 2'b00, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      check("reset_state", 2'b00, 2'b00, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         a_i = tbl[i].a;
         b_i = tbl[i].b;
         clr_err_i = tbl[i].clr;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d", i), tbl[i].en, tbl[i].ex, tbl[i].cnt,
               tbl[i].full, tbl[i].empty, tbl[i].ovf, tbl[i].unf);
      end
      clr_err_i = 1'b0;

      // bring count to 2, then reset while lane0 sits in ENT_AB
      step(2'b01, 2'b00);
      step(2'b01, 2'b01);
      step(2'b00, 2'b01);
      step(2'b00, 2'b00);
      check("pre_reset_cnt2", 2'b01, 2'b00, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      step(2'b01, 2'b00);
      step(2'b01, 2'b01);
      #2;
      reset = 1'b1;
      #1;
      check("async_reset", 2'b00, 2'b00, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      step(2'b00, 2'b01);
      check("post_reset_01", 2'b00, 2'b00, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      step(2'b00, 2'b00);
      check("post_reset_00", 2'b00, 2'b00, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      step(2'b00, 2'b00);
      check("post_reset_idle", 2'b00, 2'b00, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/carpark_occupancy.md
CARPARK_OCCUPANCY -- requirements
Module: carpark_occupancy

Interface
REQ-001 Parameter LANES, default 2: number of independent gate lanes (1..8).
REQ-002 Parameter CAPACITY, default 100: maximum occupancy (1..2^CNT_W-1).
REQ-003 Parameter CNT_W, default 8: occupancy counter width.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 a  input  LANES  outer beam sensor per lane, 1 = blocked.
REQ-007 b  input  LANES  inner beam sensor per lane, 1 = blocked.
REQ-008 clr_err  input  1  synchronous clear of sticky error flags.
REQ-009 enter  output  LANES  one-cycle pulse per completed entry, per lane.
REQ-010 exit  output  LANES  one-cycle pulse per completed exit, per lane.
REQ-011 count  output  CNT_W  current occupancy.
REQ-012 full  output  1  high when count == CAPACITY.
REQ-013 empty  output  1  high when count == 0.
REQ-014 err_ovf  output  1  sticky: an entry was refused at capacity.
REQ-015 err_unf  output  1  sticky: an exit was refused at zero.

Function
REQ-016 Each lane shall run an independent 7-state FSM: IDLE, ENT_A, ENT_AB, ENT_B, LV_B, LV_AB, LV_A, sampling {a[i],b[i]} every cycle.
REQ-017 Entry path: IDLE -10-> ENT_A -11-> ENT_AB -01-> ENT_B; hold input keeps state; any other input returns to IDLE.
REQ-018 Exit path: IDLE -01-> LV_B -11-> LV_AB -10-> LV_A; hold keeps state; any other input returns to IDLE.
REQ-019 From ENT_B, input 00 shall go to IDLE and assert enter[i] for exactly one cycle after that edge; from LV_A, input 00 likewise asserts exit[i].
REQ-020 Aborted sequences (any other departure to IDLE) shall produce no pulse and no count change.
REQ-021 IDLE with 00 or 11 shall remain IDLE; unencoded state values shall go to IDLE.
REQ-022 Counter update: on the same edge that enter/exit pulses are registered, count_next = count + (number of lanes entering) - (number of lanes exiting), evaluated at CNT_W+4 bits signed.
REQ-023 Simultaneous entries and exits across lanes shall net out before saturation; equal counts leave count unchanged with no error.
REQ-024 If the net result exceeds CAPACITY, count shall saturate at CAPACITY and err_ovf shall set; enter pulses are still emitted.
REQ-025 If the net result is below 0, count shall saturate at 0 and err_unf shall set; exit pulses are still emitted.
REQ-026 full and empty shall be registered, consistent with count in the same cycle.
REQ-027 clr_err shall clear both error flags on the next edge; a new error on that same edge takes priority (flag remains set).

Reset
REQ-028 Reset shall asynchronously force all lane FSMs to IDLE, enter/exit = 0, count = 0, empty = 1, full = 0, err_ovf = err_unf = 0.
REQ-029 Reset asserted mid-sequence shall discard the partial sequence; after release the lane restarts from IDLE.

Configuration
REQ-030 Macro CARPARK_SYNC_EN: when defined, each a/b bit shall pass through a two-flop synchroniser (reset to 0) before the FSM, adding 2 cycles latency to every pulse.
REQ-031 Without CARPARK_SYNC_EN, the FSMs shall sample a/b directly, with pulse latency as in REQ-019.

Verification (LANES=2, CAPACITY=3, CNT_W=8, macro undefined)
REQ-032 Lane0 {a,b} = 10,11,01,00 one cycle each -> enter[0] pulses once, one cycle after 00 is sampled; count 0->1; empty drops.
REQ-033 Lane0 10,11,10,00 (abort) -> no pulse, count unchanged.
REQ-034 Count=3; lane1 completes an entry -> enter[1] pulses, count stays 3, full=1, err_ovf=1; clr_err -> err_ovf=0.
REQ-035 Count=1; lane0 entry and lane1 exit complete on the same edge -> both pulses, count stays 1, no errors.
REQ-036 Count=0; lane1 {a,b} = 01,11,10,00 -> exit[1] pulses, count 0, err_unf=1.
REQ-037 Reset asserted while lane0 is in ENT_AB with count=2 -> count=0 immediately; after release, 01,00 produces no pulse.
